pref_parcel_buf: RTL and testbench

- Parametrised successor of the two-entry prefetch FIFO, sitting between the IF stage and the icache/MMU request path.
- Stores fetched words as a queue of 16-bit parcels, DEPTH_WORDS words deep.
- Presents a show-ahead instruction (16- or 32-bit, any halfword alignment) with its PC to IF.
- Keeps one memory request in flight, flushes on redirect and discards stale responses.

---
 rtl/pref_parcel_buf.sv | 221 ++++++++++++++++++++++
 tb/tb_pref_parcel_buf.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pref_parcel_buf.sv
// pref_parcel_buf: parcel-granular prefetch queue between IF and the
// icache/MMU request path. Fetched 32-bit words are split into 16-bit
// parcels. A show-ahead instruction and its PC are presented at the head.
// One memory request is kept in flight. A redirect flushes the queue, and a
// response to a request issued before the redirect is discarded.
// Build option: define PREF_C_EXT_EN to enable 16-bit (compressed)
// instructions and halfword-aligned redirect targets. Without it, every head
// is a 32-bit instruction and all fetches are word aligned.
module pref_parcel_buf #(
    parameter int DEPTH_WORDS = 4,
    parameter int ADDR_W      = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            redirect_i,
    input  logic [ADDR_W-1:0]               redirect_pc_i,
    output logic                            mem_req_o,
    output logic [ADDR_W-1:0]               mem_addr_o,
    input  logic                            mem_ack_i,
    input  logic [31:0]                     mem_rdata_i,
    output logic                            instr_valid_o,
    output logic [31:0]                     instr_o,
    output logic [ADDR_W-1:0]               instr_pc_o,
    output logic                            instr_comp_o,
    input  logic                            instr_ready_i,
    output logic [$clog2(2*DEPTH_WORDS):0]  fill_o
);

    localparam int NP = 2 * DEPTH_WORDS;
    localparam int PW = $clog2(NP);
    localparam int FW = PW + 1;
    localparam logic [FW:0] NP_L = (FW+1)'(NP);

    // state | meaning
    // IDLE  | no request outstanding (fetch disabled or no space reserved)
    // REQ   | mem_req_o high with mem_addr_o, waiting for mem_ack_i
    typedef enum logic {IDLE, REQ} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  fetch_addr_q, fetch_addr_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [ADDR_W-1:0]  head_pc_q, head_pc_d;
    logic               drop_q, drop_d;
    logic               skip_lo_q, skip_lo_d;
    logic               fetch_en_q, fetch_en_d;
    logic [15:0]        parcels_q [NP];
    logic [15:0]        parcels_d [NP];
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [FW-1:0]      fill_q, fill_d;

    logic [PW-1:0]      rd_ptr_p1, wr_ptr_p1;
    logic [15:0]        parcel0, parcel1;
    logic               head_comp, head_ok;
    logic               ack_fire, push_ok, pop;
    logic [FW-1:0]      push_cnt, pop_cnt;
    logic               space_ok, start_req;
    logic               pc_lo_unused;

    // Bit 0 of the redirect PC never matters; bit 1 only with compressed support.
    assign pc_lo_unused = ^redirect_pc_i[1:0];

    assign ack_fire  = (state_q == REQ) && mem_ack_i;
    assign push_ok   = ack_fire && !drop_q && !redirect_i;
    assign pop       = instr_valid_o && instr_ready_i && !redirect_i;
    assign rd_ptr_p1 = rd_ptr_q + PW'(1);
    assign wr_ptr_p1 = wr_ptr_q + PW'(1);

    assign mem_req_o  = (state_q == REQ);
    assign mem_addr_o = mem_addr_q;
    assign fill_o     = fill_q;

    // Head decode: show-ahead instruction straight from the registered queue.
    always_comb begin
        parcel0 = parcels_q[rd_ptr_q];
        parcel1 = parcels_q[rd_ptr_p1];
`ifdef PREF_C_EXT_EN
        head_comp = (parcel0[1:0] != 2'b11);
`else
        head_comp = 1'b0;
`endif
        head_ok       = head_comp ? (fill_q >= FW'(1)) : (fill_q >= FW'(2));
        instr_valid_o = head_ok;
        instr_comp_o  = head_ok && head_comp;
        instr_pc_o    = head_pc_q;
        instr_o       = 32'h0000_0013;
        if (head_ok) begin
            instr_o = head_comp ? {16'h0000, parcel0} : {parcel1, parcel0};
        end
    end

    // Parcel queue: push on accepted response, pop on consume, clear on redirect.
    always_comb begin
        parcels_d = parcels_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        fill_d    = fill_q;
        push_cnt  = '0;
        pop_cnt   = '0;
        if (redirect_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            fill_d   = '0;
        end else begin
            if (push_ok) begin
                if (skip_lo_q) begin
                    // Redirect landed on the upper halfword: drop the lower parcel.
                    parcels_d[wr_ptr_q] = mem_rdata_i[31:16];
                    push_cnt = FW'(1);
                end else begin
                    parcels_d[wr_ptr_q]  = mem_rdata_i[15:0];
                    parcels_d[wr_ptr_p1] = mem_rdata_i[31:16];
                    push_cnt = FW'(2);
                end
            end
            if (pop) begin
                pop_cnt = instr_comp_o ? FW'(1) : FW'(2);
            end
            wr_ptr_d = wr_ptr_q + PW'(push_cnt);
            rd_ptr_d = rd_ptr_q + PW'(pop_cnt);
            fill_d   = fill_q + push_cnt - pop_cnt;
        end
    end

    // Fetch control and request FSM next state.
    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        mem_addr_d   = mem_addr_q;
        head_pc_d    = head_pc_q;
        drop_d       = drop_q;
        skip_lo_d    = skip_lo_q;
        fetch_en_d   = fetch_en_q;
        start_req    = 1'b0;

        if (redirect_i) begin
            fetch_en_d   = 1'b1;
            fetch_addr_d = {redirect_pc_i[ADDR_W-1:2], 2'b00};
`ifdef PREF_C_EXT_EN
            head_pc_d    = {redirect_pc_i[ADDR_W-1:1], 1'b0};
            skip_lo_d    = redirect_pc_i[1];
`else
            head_pc_d    = {redirect_pc_i[ADDR_W-1:2], 2'b00};
            skip_lo_d    = 1'b0;
`endif
        end else begin
            if (push_ok) begin
                fetch_addr_d = fetch_addr_q + ADDR_W'(4);
                skip_lo_d    = 1'b0;
            end
            if (pop) begin
                head_pc_d = head_pc_q + (instr_comp_o ? ADDR_W'(2) : ADDR_W'(4));
            end
        end

        // A redirect with a request still outstanding marks its response stale.
        if (ack_fire) begin
            drop_d = 1'b0;
        end else if (redirect_i && (state_q == REQ)) begin
            drop_d = 1'b1;
        end

        // Space for a whole word is reserved before the request goes out.
        space_ok = (({1'b0, fill_d}) + (FW+1)'(2)) <= NP_L;

        case (state_q)
            IDLE: begin
                if (fetch_en_d && space_ok) begin
                    start_req = 1'b1;
                end
            end
            REQ: begin
                if (ack_fire) begin
                    if (fetch_en_d && space_ok) begin
                        start_req = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (start_req) begin
            state_d    = REQ;
            mem_addr_d = fetch_addr_d;
        end
    end

    // State and queue registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            fetch_addr_q <= '0;
            mem_addr_q   <= '0;
            head_pc_q    <= '0;
            drop_q       <= 1'b0;
            skip_lo_q    <= 1'b0;
            fetch_en_q   <= 1'b0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            fill_q       <= '0;
            for (int i = 0; i < NP; i++) begin
                parcels_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            mem_addr_q   <= mem_addr_d;
            head_pc_q    <= head_pc_d;
            drop_q       <= drop_d;
            skip_lo_q    <= skip_lo_d;
            fetch_en_q   <= fetch_en_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            fill_q       <= fill_d;
            parcels_q    <= parcels_d;
        end
    end

endmodule

// File: tb/tb_pref_parcel_buf.sv
// Directed bench for pref_parcel_buf (DEPTH_WORDS=4, ADDR_W=32).
// Expectations follow PREF_C_EXT_EN the same way the design does.
module tb_pref_parcel_buf;

    localparam int DEPTH_WORDS = 4;
    localparam int ADDR_W      = 32;
    localparam int FILL_W      = $clog2(2*DEPTH_WORDS) + 1;

    logic              clk;
    logic              reset;
    logic              redirect_i;
    logic [ADDR_W-1:0] redirect_pc_i;
    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_ack_i;
    logic [31:0]       mem_rdata_i;
    logic              instr_valid_o;
    logic [31:0]       instr_o;
    logic [ADDR_W-1:0] instr_pc_o;
    logic              instr_comp_o;
    logic              instr_ready_i;
    logic [FILL_W-1:0] fill_o;

    int checks;
    int failures;

    pref_parcel_buf #(.DEPTH_WORDS(DEPTH_WORDS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .instr_valid_o(instr_valid_o), .instr_o(instr_o),
        .instr_pc_o(instr_pc_o), .instr_comp_o(instr_comp_o),
        .instr_ready_i(instr_ready_i), .fill_o(fill_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        redirect_i = 1'b0;
        mem_ack_i = 1'b0;
        instr_ready_i = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic redirect(input logic [ADDR_W-1:0] pc);
        redirect_i = 1'b1;
        redirect_pc_i = pc;
        step();
        redirect_i = 1'b0;
    endtask

    task automatic pop_one();
        instr_ready_i = 1'b1;
        step();
        instr_ready_i = 1'b0;
    endtask

    // Wait (bounded) for a request, check its address, answer it in one cycle.
    task automatic ack_word(input logic [31:0] data, input logic [ADDR_W-1:0] exp_addr);
        int n = 0;
        while (mem_req_o !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (mem_req_o !== 1'b1) begin
            failures++;
            $display("FAIL req_timeout: mem_req_o=%b want 1 (addr %h)", mem_req_o, exp_addr);
        end else begin
            checks++;
            if (mem_addr_o !== exp_addr) begin
                failures++;
                $display("FAIL req_addr: got %h want %h", mem_addr_o, exp_addr);
            end
            mem_ack_i = 1'b1;
            mem_rdata_i = data;
            step();
            mem_ack_i = 1'b0;
        end
    endtask

    task automatic test_reset();
        #3;
        checks++; if (mem_req_o !== 1'b0) begin failures++; $display("FAIL rst_req: got %b want 0", mem_req_o); end
        checks++; if (mem_addr_o !== 32'h0) begin failures++; $display("FAIL rst_addr: got %h want 0", mem_addr_o); end
        checks++; if (fill_o !== 4'd0) begin failures++; $display("FAIL rst_fill: got %0d want 0", fill_o); end
        checks++; if (instr_valid_o !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b want 0", instr_valid_o); end
        checks++; if (instr_o !== 32'h13) begin failures++; $display("FAIL rst_instr: got %h want 00000013", instr_o); end
        checks++; if (instr_pc_o !== 32'h0) begin failures++; $display("FAIL rst_pc: got %h want 0", instr_pc_o); end
        checks++; if (instr_comp_o !== 1'b0) begin failures++; $display("FAIL rst_comp: got %b want 0", instr_comp_o); end
        step();
        reset = 1'b0;
        repeat (4) step();
        checks++; if (mem_req_o !== 1'b0) begin failures++; $display("FAIL no_fetch_before_redirect: got %b want 0", mem_req_o); end
        redirect(32'h1000);
        ack_word(32'h00B5_0513, 32'h1000);
        checks++; if (mem_req_o !== 1'b1) begin failures++; $display("FAIL pre_rst_req: got %b want 1", mem_req_o); end
        checks++; if (fill_o !== 4'd2) begin failures++; $display("FAIL pre_rst_fill: got %0d want 2", fill_o); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (mem_req_o !== 1'b0) begin failures++; $display("FAIL midreq_rst_req: got %b want 0", mem_req_o); end
        checks++; if (fill_o !== 4'd0) begin failures++; $display("FAIL midreq_rst_fill: got %0d want 0", fill_o); end
        checks++; if (instr_o !== 32'h13) begin failures++; $display("FAIL midreq_rst_instr: got %h want 00000013", instr_o); end
        checks++; if (mem_addr_o !== 32'h0) begin failures++; $display("FAIL midreq_rst_addr: got %h want 0", mem_addr_o); end
        step();
        reset = 1'b0;
        repeat (3) step();
        checks++; if (mem_req_o !== 1'b0) begin failures++; $display("FAIL post_rst_idle: got %b want 0", mem_req_o); end
    endtask

    task automatic test_decode_and_drop();
        do_reset();
        redirect(32'h1000);
        checks++; if (mem_req_o !== 1'b1) begin failures++; $display("FAIL latency_req: got %b want 1", mem_req_o); end
        ack_word(32'h00B5_0513, 32'h1000);
        checks++; if (instr_valid_o !== 1'b1) begin failures++; $display("FAIL w0_valid: got %b want 1", instr_valid_o); end
        checks++; if (instr_o !== 32'h00B5_0513) begin failures++; $display("FAIL w0_instr: got %h want 00b50513", instr_o); end
        checks++; if (instr_pc_o !== 32'h1000) begin failures++; $display("FAIL w0_pc: got %h want 1000", instr_pc_o); end
        checks++; if (instr_comp_o !== 1'b0) begin failures++; $display("FAIL w0_comp: got %b want 0", instr_comp_o); end
        pop_one();
        checks++; if (fill_o !== 4'd0) begin failures++; $display("FAIL pop32_fill: got %0d want 0", fill_o); end
        ack_word(32'h0001_4501, 32'h1004);
`ifdef PREF_C_EXT_EN
        checks++; if (instr_o !== 32'h0000_4501) begin failures++; $display("FAIL c0_instr: got %h want 00004501", instr_o); end
        checks++; if (instr_pc_o !== 32'h1004) begin failures++; $display("FAIL c0_pc: got %h want 1004", instr_pc_o); end
        checks++; if (instr_comp_o !== 1'b1) begin failures++; $display("FAIL c0_comp: got %b want 1", instr_comp_o); end
        pop_one();
        checks++; if (instr_o !== 32'h0000_0001) begin failures++; $display("FAIL c1_instr: got %h want 00000001", instr_o); end
        checks++; if (instr_pc_o !== 32'h1006) begin failures++; $display("FAIL c1_pc: got %h want 1006", instr_pc_o); end
        checks++; if (instr_comp_o !== 1'b1) begin failures++; $display("FAIL c1_comp: got %b want 1", instr_comp_o); end
        checks++; if (fill_o !== 4'd1) begin failures++; $display("FAIL c1_fill: got %0d want 1", fill_o); end
        pop_one();
`else
        checks++; if (instr_o !== 32'h0001_4501) begin failures++; $display("FAIL w1_instr: got %h want 00014501", instr_o); end
        checks++; if (instr_pc_o !== 32'h1004) begin failures++; $display("FAIL w1_pc: got %h want 1004", instr_pc_o); end
        checks++; if (instr_comp_o !== 1'b0) begin failures++; $display("FAIL w1_comp: got %b want 0", instr_comp_o); end
        pop_one();
`endif
        checks++; if (instr_pc_o !== 32'h1008) begin failures++; $display("FAIL drained_pc: got %h want 1008", instr_pc_o); end
        repeat (3) step();
        checks++; if (mem_addr_o !== 32'h1008 || mem_req_o !== 1'b1) begin failures++; $display("FAIL pending_req: req=%b addr=%h want 1/1008", mem_req_o, mem_addr_o); end
        redirect(32'h3000);
        checks++; if (mem_addr_o !== 32'h1008 || mem_req_o !== 1'b1) begin failures++; $display("FAIL held_after_redirect: req=%b addr=%h want 1/1008", mem_req_o, mem_addr_o); end
        checks++; if (instr_pc_o !== 32'h3000) begin failures++; $display("FAIL redirect_pc: got %h want 3000", instr_pc_o); end
        step();
        ack_word(32'hDEAD_BEEF, 32'h1008);
        checks++; if (fill_o !== 4'd0 || instr_valid_o !== 1'b0) begin failures++; $display("FAIL stale_dropped: fill=%0d valid=%b want 0/0", fill_o, instr_valid_o); end
        checks++; if (mem_addr_o !== 32'h3000 || mem_req_o !== 1'b1) begin failures++; $display("FAIL new_req_after_drop: req=%b addr=%h want 1/3000", mem_req_o, mem_addr_o); end
        ack_word(32'h0000_0013, 32'h3000);
        checks++; if (instr_o !== 32'h13 || instr_pc_o !== 32'h3000 || fill_o !== 4'd2) begin failures++; $display("FAIL after_drop_head: instr=%h pc=%h fill=%0d want 13/3000/2", instr_o, instr_pc_o, fill_o); end
    endtask

    task automatic test_backpressure();
        int acks = 0;
        do_reset();
        redirect(32'h5000);
        for (int i = 0; i < 20; i++) begin
            mem_ack_i = mem_req_o;
            mem_rdata_i = {mem_addr_o[15:0], 16'h0013};
            if (mem_req_o === 1'b1) acks++;
            step();
        end
        mem_ack_i = 1'b0;
        checks++; if (acks != 4) begin failures++; $display("FAIL full_acks: got %0d want 4", acks); end
        checks++; if (fill_o !== 4'd8) begin failures++; $display("FAIL full_fill: got %0d want 8", fill_o); end
        checks++; if (mem_req_o !== 1'b0) begin failures++; $display("FAIL full_no_req: got %b want 0", mem_req_o); end
        checks++; if (instr_o !== 32'h5000_0013 || instr_pc_o !== 32'h5000) begin failures++; $display("FAIL full_head: instr=%h pc=%h want 50000013/5000", instr_o, instr_pc_o); end
        pop_one();
        checks++; if (fill_o !== 4'd6) begin failures++; $display("FAIL pop_full_fill: got %0d want 6", fill_o); end
        checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h5010) begin failures++; $display("FAIL refill_req: req=%b addr=%h want 1/5010", mem_req_o, mem_addr_o); end
        checks++; if (instr_o !== 32'h5004_0013 || instr_pc_o !== 32'h5004) begin failures++; $display("FAIL next_head: instr=%h pc=%h want 50040013/5004", instr_o, instr_pc_o); end
        ack_word(32'h5010_0013, 32'h5010);
        checks++; if (fill_o !== 4'd8 || mem_req_o !== 1'b0) begin failures++; $display("FAIL refull: fill=%0d req=%b want 8/0", fill_o, mem_req_o); end
    endtask

    task automatic test_redirect_with_ack();
        do_reset();
        redirect(32'h6000);
        redirect_i = 1'b1;
        redirect_pc_i = 32'h7000;
        mem_ack_i = 1'b1;
        mem_rdata_i = 32'hAAAA_0013;
        step();
        redirect_i = 1'b0;
        mem_ack_i = 1'b0;
        checks++; if (fill_o !== 4'd0 || instr_valid_o !== 1'b0) begin failures++; $display("FAIL coincide_discard: fill=%0d valid=%b want 0/0", fill_o, instr_valid_o); end
        checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h7000) begin failures++; $display("FAIL coincide_new_req: req=%b addr=%h want 1/7000", mem_req_o, mem_addr_o); end
        ack_word(32'h7000_0013, 32'h7000);
        checks++; if (instr_o !== 32'h7000_0013 || instr_pc_o !== 32'h7000) begin failures++; $display("FAIL coincide_head: instr=%h pc=%h want 70000013/7000", instr_o, instr_pc_o); end
        instr_ready_i = 1'b1;
        redirect(32'h8000);
        instr_ready_i = 1'b0;
        checks++; if (instr_pc_o !== 32'h8000 || fill_o !== 4'd0) begin failures++; $display("FAIL redirect_pop: pc=%h fill=%0d want 8000/0", instr_pc_o, fill_o); end
        ack_word(32'h1111_0013, 32'h7004);
        checks++; if (mem_addr_o !== 32'h8000 || fill_o !== 4'd0) begin failures++; $display("FAIL redirect_pop_drop: addr=%h fill=%0d want 8000/0", mem_addr_o, fill_o); end
    endtask

    task automatic test_alignment();
        do_reset();
`ifdef PREF_C_EXT_EN
        redirect(32'h2002);
        checks++; if (mem_addr_o !== 32'h2000 || instr_pc_o !== 32'h2002) begin failures++; $display("FAIL straddle_start: addr=%h pc=%h want 2000/2002", mem_addr_o, instr_pc_o); end
        ack_word(32'h0513_ABCD, 32'h2000);
        checks++; if (instr_valid_o !== 1'b0 || fill_o !== 4'd1) begin failures++; $display("FAIL straddle_wait: valid=%b fill=%0d want 0/1", instr_valid_o, fill_o); end
        ack_word(32'h1234_00B5, 32'h2004);
        checks++; if (instr_valid_o !== 1'b1 || instr_o !== 32'h00B5_0513) begin failures++; $display("FAIL straddle_instr: valid=%b instr=%h want 1/00b50513", instr_valid_o, instr_o); end
        checks++; if (instr_pc_o !== 32'h2002 || instr_comp_o !== 1'b0 || fill_o !== 4'd3) begin failures++; $display("FAIL straddle_meta: pc=%h comp=%b fill=%0d want 2002/0/3", instr_pc_o, instr_comp_o, fill_o); end
`else
        redirect(32'h4002);
        checks++; if (mem_addr_o !== 32'h4000 || instr_pc_o !== 32'h4000) begin failures++; $display("FAIL align_start: addr=%h pc=%h want 4000/4000", mem_addr_o, instr_pc_o); end
        ack_word(32'h0001_4501, 32'h4000);
        checks++; if (instr_o !== 32'h0001_4501 || instr_comp_o !== 1'b0 || fill_o !== 4'd2) begin failures++; $display("FAIL align_head: instr=%h comp=%b fill=%0d want 00014501/0/2", instr_o, instr_comp_o, fill_o); end
        pop_one();
        ack_word(32'h0000_4501, 32'h4004);
        checks++; if (instr_pc_o !== 32'h4004 || instr_comp_o !== 1'b0 || instr_valid_o !== 1'b1) begin failures++; $display("FAIL align_next: pc=%h comp=%b valid=%b want 4004/0/1", instr_pc_o, instr_comp_o, instr_valid_o); end
`endif
    endtask

    task automatic test_wrap();
        do_reset();
        redirect(32'hFFFF_FFFC);
        ack_word(32'h0000_0013, 32'hFFFF_FFFC);
        checks++; if (mem_addr_o !== 32'h0 || mem_req_o !== 1'b1) begin failures++; $display("FAIL wrap_addr: req=%b addr=%h want 1/0", mem_req_o, mem_addr_o); end
        checks++; if (instr_pc_o !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_pc0: got %h want fffffffc", instr_pc_o); end
        pop_one();
        checks++; if (instr_pc_o !== 32'h0) begin failures++; $display("FAIL wrap_pc1: got %h want 0", instr_pc_o); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        redirect_i = 1'b0;
        redirect_pc_i = '0;
        mem_ack_i = 1'b0;
        mem_rdata_i = '0;
        instr_ready_i = 1'b0;
        test_reset();
        test_decode_and_drop();
        test_backpressure();
        test_redirect_with_ack();
        test_alignment();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
